// File: rtl/datapath_sequencer_pkg.sv
// Shared types and encodings for the LEGv8 multi-cycle control unit.
// The control word struct is laid out MSB-first exactly as driven on controlWord.
package datapath_sequencer_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CTRL_W  = 31;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        HALT
    } state_t;

    typedef enum logic [3:0] {
        IC_ALU,
        IC_LOAD,
        IC_STORE,
        IC_B,
        IC_CBZ,
        IC_CBNZ,
        IC_BCOND,
        IC_BR,
        IC_ILLEGAL
    } iclass_t;

    // ALU function select
    localparam logic [4:0] FS_AND    = 5'b00000;
    localparam logic [4:0] FS_OR     = 5'b00100;
    localparam logic [4:0] FS_ADD    = 5'b01000;
    localparam logic [4:0] FS_SUB    = 5'b01001;
    localparam logic [4:0] FS_PASS_B = 5'b11100;

    // PC update select
    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_LOAD = 2'b10;

    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_BR    = 11'b11010110000;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B     = 6'b000101;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    // Bit offsets of each field within controlWord
    localparam int unsigned CW_SL_BIT     = 0;
    localparam int unsigned CW_PCSEL_BIT  = 1;
    localparam int unsigned CW_SELB_BIT   = 2;
    localparam int unsigned CW_EN_PC_BIT  = 3;
    localparam int unsigned CW_EN_B_BIT   = 4;
    localparam int unsigned CW_EN_ALU_BIT = 5;
    localparam int unsigned CW_EN_MEM_BIT = 6;
    localparam int unsigned CW_RAMW_BIT   = 7;
    localparam int unsigned CW_REGW_BIT   = 8;
    localparam int unsigned CW_FS_LSB     = 9;
    localparam int unsigned CW_SB_LSB     = 14;
    localparam int unsigned CW_SA_LSB     = 19;
    localparam int unsigned CW_DA_LSB     = 24;
    localparam int unsigned CW_PS_LSB     = 29;

    typedef struct packed {
        logic [1:0] ps;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] fs;
        logic       reg_w;
        logic       ram_w;
        logic       en_mem;
        logic       en_alu;
        logic       en_b;
        logic       en_pc;
        logic       sel_b;
        logic       pc_sel;
        logic       sl;
    } ctrl_word_t;

    function automatic logic [4:0] alu_fs(input logic [10:0] op);
        logic [4:0] fs;
        case (op)
            OP_AND:          fs = FS_AND;
            OP_ORR:          fs = FS_OR;
            OP_SUB, OP_SUBS: fs = FS_SUB;
            default:         fs = FS_ADD;
        endcase
        return fs;
    endfunction

    // Condition evaluation on registered {V,C,Z,N}; code 4'hF behaves as always
    function automatic logic cond_taken(input logic [3:0] cond, input logic [3:0] vczn);
        logic v, c, z, n, t;
        {v, c, z, n} = vczn;
        case (cond)
            COND_EQ: t = z;
            COND_NE: t = ~z;
            COND_HS: t = c;
            COND_LO: t = ~c;
            COND_MI: t = n;
            COND_PL: t = ~n;
            COND_VS: t = v;
            COND_VC: t = ~v;
            COND_HI: t = c & ~z;
            COND_LS: t = ~(c & ~z);
            COND_GE: t = (n == v);
            COND_LT: t = (n != v);
            COND_GT: t = ~z & (n == v);
            COND_LE: t = z | (n != v);
            COND_AL: t = 1'b1;
            default: t = 1'b1;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/datapath_sequencer_seq_decoder.sv
// Combinational instruction decoder: classifies IR and produces the K constant
// and the EXEC-state control fields before any state-dependent overrides.
module seq_decoder
    import datapath_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [INSTR_W-1:0] ir,
    input  logic [DATA_W-1:0]  pc,
    output iclass_t            iclass_c,
    output logic [DATA_W-1:0]  k_value_c,
    output ctrl_word_t         base_cw_c
);

    logic [10:0]       op11;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [DATA_W-1:0] imm12_z;
    logic [DATA_W-1:0] imm9_s;
    logic [DATA_W-1:0] br26_target;
    logic [DATA_W-1:0] br19_target;

    assign op11 = ir[31:21];
    assign rd   = ir[4:0];
    assign rn   = ir[9:5];
    assign rm   = ir[20:16];

    assign imm12_z     = DATA_W'(ir[21:10]);
    assign imm9_s      = {{(DATA_W-9){ir[20]}}, ir[20:12]};
    assign br26_target = pc + {{(DATA_W-28){ir[25]}}, ir[25:0], 2'b00};
    assign br19_target = pc + {{(DATA_W-21){ir[23]}}, ir[23:5], 2'b00};

    // Shorter opcode prefixes are matched first so they cannot alias 11-bit R/D opcodes
    always_comb begin
        iclass_c  = IC_ILLEGAL;
        k_value_c = '0;
        base_cw_c = '0;
        if (ir[31:26] == OP_B) begin
            iclass_c         = IC_B;
            k_value_c        = br26_target;
            base_cw_c.pc_sel = 1'b1;
            base_cw_c.ps     = PS_LOAD;
        end else if (ir[31:24] == OP_CBZ || ir[31:24] == OP_CBNZ) begin
            iclass_c         = (ir[31:24] == OP_CBZ) ? IC_CBZ : IC_CBNZ;
            k_value_c        = br19_target;
            base_cw_c.sb     = rd;
            base_cw_c.fs     = FS_PASS_B;
            base_cw_c.pc_sel = 1'b1;
            base_cw_c.ps     = PS_INC;
        end else if (ir[31:24] == OP_BCOND) begin
            iclass_c         = IC_BCOND;
            k_value_c        = br19_target;
            base_cw_c.pc_sel = 1'b1;
            base_cw_c.ps     = PS_INC;
        end else if (ir[31:22] == OP_ADDI || ir[31:22] == OP_SUBI) begin
            iclass_c         = IC_ALU;
            k_value_c        = imm12_z;
            base_cw_c.da     = rd;
            base_cw_c.sa     = rn;
            base_cw_c.fs     = (ir[31:22] == OP_ADDI) ? FS_ADD : FS_SUB;
            base_cw_c.sel_b  = 1'b1;
            base_cw_c.reg_w  = 1'b1;
            base_cw_c.en_alu = 1'b1;
            base_cw_c.ps     = PS_INC;
        end else begin
            case (op11)
                OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS: begin
                    iclass_c         = IC_ALU;
                    base_cw_c.da     = rd;
                    base_cw_c.sa     = rn;
                    base_cw_c.sb     = rm;
                    base_cw_c.fs     = alu_fs(op11);
                    base_cw_c.sl     = (op11 == OP_ADDS) || (op11 == OP_SUBS);
                    base_cw_c.reg_w  = 1'b1;
                    base_cw_c.en_alu = 1'b1;
                    base_cw_c.ps     = PS_INC;
                end
                OP_LDUR: begin
                    iclass_c        = IC_LOAD;
                    k_value_c       = imm9_s;
                    base_cw_c.da    = rd;
                    base_cw_c.sa    = rn;
                    base_cw_c.sel_b = 1'b1;
                    base_cw_c.fs    = FS_ADD;
                    base_cw_c.ps    = PS_HOLD;
                end
                OP_STUR: begin
                    iclass_c        = IC_STORE;
                    k_value_c       = imm9_s;
                    base_cw_c.sa    = rn;
                    base_cw_c.sb    = rd;
                    base_cw_c.sel_b = 1'b1;
                    base_cw_c.fs    = FS_ADD;
                    base_cw_c.ram_w = 1'b1;
                    base_cw_c.ps    = PS_INC;
                end
                OP_BR: begin
                    iclass_c     = IC_BR;
                    base_cw_c.sa = rn;
                    base_cw_c.ps = PS_LOAD;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle LEGv8 sequencer: fetch handshake, decode, then one EXEC cycle
// (plus MEM for loads) driving the datapath control word and K constant.
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CW_W   = 31,
    parameter int unsigned CNT_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    input  logic               imem_valid,
    input  logic [31:0]        instr,
    input  logic [DATA_W-1:0]  pc,
    input  logic [4:0]         statusOut,
    output logic [CW_W-1:0]    controlWord,
    output logic [DATA_W-1:0]  K,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       ir_q;
    iclass_t           iclass_c;
    logic [DATA_W-1:0] k_value_c;
    ctrl_word_t        base_cw_c;
    ctrl_word_t        cw_c;
    logic              taken_c;
    logic              fetch_fire_c;
    logic              retire_c;

    seq_decoder #(
        .DATA_W (DATA_W)
    ) u_decoder (
        .ir        (ir_q),
        .pc        (pc),
        .iclass_c  (iclass_c),
        .k_value_c (k_value_c),
        .base_cw_c (base_cw_c)
    );

    assign fetch_fire_c = (state_q == FETCH) && imem_req && imem_valid;
    assign retire_c     = ((state_q == EXEC) && (iclass_c != IC_LOAD)) || (state_q == MEM);

    // Conditional branches resolve on the status present during EXEC
    always_comb begin
        taken_c = 1'b0;
        case (iclass_c)
            IC_CBZ:   taken_c = statusOut[0];
            IC_CBNZ:  taken_c = ~statusOut[0];
            IC_BCOND: taken_c = cond_taken(ir_q[3:0], statusOut[4:1]);
            default:  taken_c = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cw_c    = '0;
        case (state_q)
            FETCH: begin
                if (fetch_fire_c) state_d = DECODE;
            end
            DECODE: begin
                state_d = (iclass_c == IC_ILLEGAL) ? HALT : EXEC;
            end
            EXEC: begin
                cw_c = base_cw_c;
                if (taken_c) cw_c.ps = PS_LOAD;
                state_d = (iclass_c == IC_LOAD) ? MEM : FETCH;
            end
            MEM: begin
                cw_c        = base_cw_c;
                cw_c.en_mem = 1'b1;
                cw_c.reg_w  = 1'b1;
                cw_c.ps     = PS_INC;
                state_d     = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        // X31 reads as zero and is never written
        if (cw_c.da == 5'd31) cw_c.reg_w = 1'b0;
        if (reset) cw_c = '0;
    end

    assign controlWord = CW_W'(cw_c);

    always_ff @(posedge clock) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q     <= '0;
            K        <= '0;
            halted   <= 1'b0;
            retired  <= '0;
            imem_req <= 1'b1;
        end else begin
            if (fetch_fire_c)       ir_q    <= instr;
            if (state_q == DECODE)  K       <= k_value_c;
            if (state_d == HALT)    halted  <= 1'b1;
            if (retire_c)           retired <= retired + CNT_W'(1);
            imem_req <= (state_d == FETCH);
        end
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomised self-checking bench for datapath_sequencer against an
// instruction-level reference model of the expected control word per state.
module tb_datapath_sequencer;
    import datapath_sequencer_pkg::*;

    typedef struct packed {
        logic [1:0] ps;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] fs;
        logic       reg_w;
        logic       ram_w;
        logic       en_mem;
        logic       en_alu;
        logic       en_b;
        logic       en_pc;
        logic       sel_b;
        logic       pc_sel;
        logic       sl;
    } tcw_t;

    typedef enum int {T_ADD, T_SUB, T_AND, T_ORR, T_ADDS, T_SUBS, T_ADDI, T_SUBI,
                      T_LDUR, T_STUR, T_B, T_CBZ, T_CBNZ, T_BCOND, T_BR, T_ILL} top_t;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic        imem_valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [4:0]  status_in;
    logic [30:0] control_word;
    logic [63:0] k_out;
    logic        halted;
    logic [31:0] retired;

    int          errors = 0;
    int          checks = 0;
    int unsigned exp_retired = 0;

    datapath_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .pc          (pc),
        .statusOut   (status_in),
        .controlWord (control_word),
        .K           (k_out),
        .halted      (halted),
        .retired     (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic top_t classify(input logic [31:0] in);
        if (in[31:26] == 6'b000101) return T_B;
        if (in[31:24] == 8'hB4) return T_CBZ;
        if (in[31:24] == 8'hB5) return T_CBNZ;
        if (in[31:24] == 8'h54) return T_BCOND;
        if (in[31:22] == 10'h244) return T_ADDI;
        if (in[31:22] == 10'h344) return T_SUBI;
        case (in[31:21])
            11'h458: return T_ADD;
            11'h658: return T_SUB;
            11'h450: return T_AND;
            11'h550: return T_ORR;
            11'h558: return T_ADDS;
            11'h758: return T_SUBS;
            11'h7C2: return T_LDUR;
            11'h7C0: return T_STUR;
            11'h6B0: return T_BR;
            default: return T_ILL;
        endcase
    endfunction

    // Expected EXEC/MEM words, with care masks selecting the fields the instruction defines
    function automatic void model(input logic [31:0] in, input logic [63:0] pcv, input logic [4:0] st,
                                  output tcw_t ex, output tcw_t exc, output tcw_t mm, output tcw_t mmc,
                                  output logic [63:0] k, output logic kc, output logic is_load);
        top_t   op;
        logic   v, c, z, n, tk;
        longint off;
        op = classify(in);
        v = st[4]; c = st[3]; z = st[2]; n = st[1];
        ex = '0; exc = '0; mm = '0; mmc = '0; k = '0; kc = 1'b0; is_load = 1'b0; tk = 1'b0;
        case (op)
            T_ADD, T_SUB, T_AND, T_ORR, T_ADDS, T_SUBS, T_ADDI, T_SUBI: begin
                ex.da = in[4:0]; ex.sa = in[9:5]; ex.sb = in[20:16];
                ex.reg_w = (in[4:0] != 5'd31); ex.en_alu = 1'b1; ex.ps = 2'b01;
                ex.sl = (op == T_ADDS) || (op == T_SUBS);
                if (op == T_AND) ex.fs = FS_AND;
                else if (op == T_ORR) ex.fs = FS_OR;
                else if (op == T_SUB || op == T_SUBS || op == T_SUBI) ex.fs = FS_SUB;
                else ex.fs = FS_ADD;
                exc = '1;
                if (op == T_ADDI || op == T_SUBI) begin
                    ex.sel_b = 1'b1; exc.sb = '0; k = 64'(in[21:10]); kc = 1'b1;
                end
            end
            T_LDUR, T_STUR: begin
                ex.sa = in[9:5]; ex.sel_b = 1'b1; ex.fs = FS_ADD;
                exc = '1; exc.da = '0;
                off = $signed(in[20:12]); k = 64'(off); kc = 1'b1;
                if (op == T_STUR) begin
                    ex.sb = in[4:0]; ex.ram_w = 1'b1; ex.ps = 2'b01;
                end else begin
                    exc.sb = '0; ex.ps = 2'b00; is_load = 1'b1;
                    mm = ex; mm.en_mem = 1'b1; mm.da = in[4:0]; mm.reg_w = (in[4:0] != 5'd31); mm.ps = 2'b01;
                    mmc = '1; mmc.sb = '0;
                end
            end
            T_B: begin
                ex.pc_sel = 1'b1; ex.ps = 2'b10;
                exc.pc_sel = 1'b1; exc.ps = '1; exc.reg_w = 1'b1; exc.ram_w = 1'b1;
                off = $signed({in[25:0], 2'b00}); k = pcv + 64'(off); kc = 1'b1;
            end
            T_CBZ, T_CBNZ, T_BCOND: begin
                if (op == T_CBZ) tk = st[0];
                else if (op == T_CBNZ) tk = !st[0];
                else begin
                    case (in[3:0])
                        4'h0: tk = z;          4'h1: tk = !z;
                        4'h2: tk = c;          4'h3: tk = !c;
                        4'h4: tk = n;          4'h5: tk = !n;
                        4'h6: tk = v;          4'h7: tk = !v;
                        4'h8: tk = c && !z;    4'h9: tk = !c || z;
                        4'hA: tk = (n == v);   4'hB: tk = (n != v);
                        4'hC: tk = !z && (n == v);
                        4'hD: tk = z || (n != v);
                        default: tk = 1'b1;
                    endcase
                end
                ex.pc_sel = 1'b1; ex.ps = tk ? 2'b10 : 2'b01;
                exc.pc_sel = 1'b1; exc.ps = '1; exc.reg_w = 1'b1; exc.ram_w = 1'b1;
                if (op != T_BCOND) begin
                    ex.sb = in[4:0]; ex.fs = FS_PASS_B; ex.sel_b = 1'b0;
                    exc.sb = '1; exc.fs = '1; exc.sel_b = 1'b1;
                end
                off = $signed({in[23:5], 2'b00}); k = pcv + 64'(off); kc = 1'b1;
            end
            T_BR: begin
                ex.sa = in[9:5]; ex.pc_sel = 1'b0; ex.ps = 2'b10;
                exc.sa = '1; exc.pc_sel = 1'b1; exc.ps = '1; exc.reg_w = 1'b1; exc.ram_w = 1'b1;
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 13))
            0:  r[31:21] = 11'h458;
            1:  r[31:21] = 11'h658;
            2:  r[31:21] = 11'h450;
            3:  r[31:21] = 11'h550;
            4:  r[31:21] = 11'h558;
            5:  r[31:21] = 11'h758;
            6:  r[31:22] = 10'h244;
            7:  r[31:22] = 10'h344;
            8:  r[31:21] = 11'h7C2;
            9:  r[31:21] = 11'h7C0;
            10: r[31:26] = 6'b000101;
            11: r[31:24] = ($urandom_range(0, 1) == 0) ? 8'hB4 : 8'hB5;
            12: r[31:24] = 8'h54;
            default: r[31:21] = 11'h6B0;
        endcase
        if ($urandom_range(0, 5) == 0) r[4:0] = 5'd31;
        return r;
    endfunction

    // Drives one fetch and records the word seen in DECODE, EXEC and (if any) MEM
    task automatic run_instr(input logic [31:0] in, input logic [63:0] pcv, input logic [4:0] st,
                             input int waits, input logic valid_high,
                             output tcw_t cw_dec, output logic req_dec, output tcw_t cw_ex,
                             output logic [63:0] k_ex, output tcw_t cw_mem, output int cycles,
                             output logic timed_out);
        timed_out = 1'b0;
        cw_mem = '0;
        cw_dec = '0;
        cw_ex = '0;
        k_ex = '0;
        req_dec = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clock);
        if (!imem_req) begin
            timed_out = 1'b1;
            return;
        end
        pc = pcv;
        status_in = st;
        instr = in;
        for (int i = 0; i < waits; i++) begin
            imem_valid = 1'b0;
            @(negedge clock);
        end
        imem_valid = 1'b1;
        @(negedge clock);
        cw_dec = control_word;
        req_dec = imem_req;
        imem_valid = valid_high;
        instr = $urandom;
        @(negedge clock);
        cw_ex = control_word;
        k_ex = k_out;
        cycles = 3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (imem_req) break;
            cycles++;
            cw_mem = control_word;
        end
        if (!imem_req) timed_out = 1'b1;
        if (!valid_high) imem_valid = 1'b0;
    endtask

    // Applies one instruction and checks every observable against the model
    task automatic check_instr(input string tag, input logic [31:0] in, input logic [63:0] pcv,
                               input logic [4:0] st, input int waits, input logic valid_high);
        tcw_t        ex, exc, mm, mmc, cw_dec, cw_ex, cw_mem;
        logic [63:0] k, k_ex;
        logic        kc, is_load, req_dec, to;
        int          cycles;
        model(in, pcv, st, ex, exc, mm, mmc, k, kc, is_load);
        run_instr(in, pcv, st, waits, valid_high, cw_dec, req_dec, cw_ex, k_ex, cw_mem, cycles, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s timeout instr=%h", tag, in);
            return;
        end
        exp_retired++;
        checks++;
        if (cw_dec !== 31'h0 || req_dec !== 1'b0) begin
            errors++;
            $display("FAIL %s decode_idle instr=%h got cw=%h req=%b want cw=0 req=0", tag, in, cw_dec, req_dec);
        end
        checks++;
        if ((cw_ex & exc) !== (ex & exc)) begin
            errors++;
            $display("FAIL %s exec_cw instr=%h st=%b got=%h want=%h care=%h", tag, in, st, cw_ex, ex, exc);
        end
        if (kc) begin
            checks++;
            if (k_ex !== k) begin
                errors++;
                $display("FAIL %s k instr=%h pc=%h got=%h want=%h", tag, in, pcv, k_ex, k);
            end
        end
        if (is_load) begin
            checks++;
            if ((cw_mem & mmc) !== (mm & mmc)) begin
                errors++;
                $display("FAIL %s mem_cw instr=%h got=%h want=%h care=%h", tag, in, cw_mem, mm, mmc);
            end
        end
        checks++;
        if (cycles !== (is_load ? 4 : 3)) begin
            errors++;
            $display("FAIL %s latency instr=%h got=%0d want=%0d", tag, in, cycles, is_load ? 4 : 3);
        end
        checks++;
        if (retired !== exp_retired) begin
            errors++;
            $display("FAIL %s retired got=%0d want=%0d", tag, retired, exp_retired);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_valid = 1'b0;
        instr = '0;
        pc = '0;
        status_in = '0;
        repeat (3) @(negedge clock);
        checks++;
        if (control_word !== 31'h0 || halted !== 1'b0 || retired !== 32'h0 || k_out !== 64'h0) begin
            errors++;
            $display("FAIL reset_values got cw=%h halted=%b retired=%0d k=%h want all zero",
                     control_word, halted, retired, k_out);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b1 || control_word !== 31'h0) begin
            errors++;
            $display("FAIL reset_fetch got req=%b cw=%h want req=1 cw=0", imem_req, control_word);
        end
        exp_retired = 0;
    endtask

    task automatic test_addi();
        check_instr("addi", 32'h910017E1, 64'h0000_0000_0000_2000, 5'($urandom_range(0, 31)), 2, 1'b0);
    endtask

    task automatic test_back_to_back();
        check_instr("add_b2b0", 32'h8B020023, 64'h40, 5'($urandom_range(0, 31)), 0, 1'b1);
        check_instr("add_b2b1", 32'h8B020023, 64'h44, 5'($urandom_range(0, 31)), 0, 1'b1);
        imem_valid = 1'b0;
    endtask

    task automatic test_load();
        check_instr("ldur", 32'hF8408024, 64'h80, 5'($urandom_range(0, 31)), 0, 1'b0);
    endtask

    task automatic test_cbz();
        check_instr("cbz_taken", 32'hB4000061, 64'h100, 5'b10101, 0, 1'b0);
        check_instr("cbz_fall", 32'hB4000061, 64'h100, 5'b01110, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [63:0] pcv;
        for (int i = 0; i < 60; i++) begin
            pcv = {32'($urandom), 32'($urandom)} & ~64'h3;
            check_instr("rand", rand_instr(), pcv, 5'($urandom_range(0, 31)),
                        $urandom_range(0, 2), 1'b0);
        end
    endtask

    task automatic test_reset_mid_exec();
        logic [31:0] stur;
        stur = {11'h7C0, 9'd16, 2'b00, 5'd2, 5'd5};
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clock);
        instr = stur;
        imem_valid = 1'b1;
        @(negedge clock);
        imem_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (control_word[7] !== 1'b1) begin
            errors++;
            $display("FAIL stur_exec_ramw got=%b want=1", control_word[7]);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (control_word !== 31'h0) begin
            errors++;
            $display("FAIL reset_forces_cw got=%h want=0", control_word);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (control_word[7] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ramw cycle=%0d got=%b want=0", i, control_word[7]);
            end
        end
        reset = 1'b0;
        exp_retired = 0;
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b1 || retired !== 32'h0 || control_word !== 31'h0) begin
            errors++;
            $display("FAIL after_reset got req=%b retired=%0d cw=%h want req=1 retired=0 cw=0",
                     imem_req, retired, control_word);
        end
    endtask

    task automatic test_halt();
        int bad;
        for (int i = 0; i < 20 && !imem_req; i++) @(negedge clock);
        instr = 32'hFFFF_FFFF;
        imem_valid = 1'b1;
        @(negedge clock);
        checks++;
        if (halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_early got=%b want=0", halted);
        end
        @(negedge clock);
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || control_word !== 31'h0) begin
            errors++;
            $display("FAIL halt_enter got halted=%b req=%b cw=%h want 1 0 0", halted, imem_req, control_word);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            instr = rand_instr();
            @(negedge clock);
            if (halted !== 1'b1 || imem_req !== 1'b0 || control_word !== 31'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL halt_sticky bad_cycles=%0d want 0", bad);
        end
        checks++;
        if (retired !== exp_retired) begin
            errors++;
            $display("FAIL halt_retired got=%0d want=%0d", retired, exp_retired);
        end
        imem_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_retired = 0;
        @(negedge clock);
        checks++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || retired !== 32'h0) begin
            errors++;
            $display("FAIL halt_clear got halted=%b req=%b retired=%0d want 0 1 0", halted, imem_req, retired);
        end
    endtask

    initial begin
        reset = 1'b1;
        imem_valid = 1'b0;
        instr = '0;
        pc = '0;
        status_in = '0;
        @(negedge clock);
        test_reset();
        test_addi();
        test_back_to_back();
        test_load();
        test_cbz();
        test_random();
        test_reset_mid_exec();
        check_instr("post_reset", 32'h8B020023, 64'h200, 5'd0, 0, 1'b0);
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle control unit that sequences the register/ALU/RAM datapath.
- Fetches a 32-bit LEGv8 instruction over a request/valid handshake and decodes it.
- Drives the 31-bit datapath control word and the K constant one state at a time.
- Uses the datapath's 5-bit status (registered V,C,Z,N plus live zero) to resolve conditional branches.

Parameters:
- DATA_W, 64, datapath word width (K, pc)
- CW_W, 31, control word width
- CNT_W, 32, width of retired-instruction counter

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_valid  in  1  instruction word valid (fetch handshake)
- instr  in  32  instruction word, sampled when imem_req && imem_valid
- pc  in  DATA_W  address of the current instruction
- statusOut  in  5  {V,C,Z,N registered, Z live} from datapath
- controlWord  out  CW_W  {PS[1:0],DA,SA,SB,FS[4:0],regW,ramW,EN_MEM,EN_ALU,EN_B,EN_PC,selB,PCsel,SL}
- K  out  DATA_W  constant / branch target to datapath
- halted  out  1  sticky illegal-opcode flag
- retired  out  CNT_W  completed-instruction count

Behaviour:
- One clock (clock); reset synchronous active-high. Reset edge → state FETCH, IR=0, K=0, halted=0, retired=0.
- While reset=1, controlWord forced to 0 combinationally (no regW/ramW/SL/PC change on the reset edge).
- controlWord=0 means: PS=00 (hold), no writes, data bus undriven. It is 0 in every state except EXEC and MEM.
- PS encoding: 00 hold, 01 PC+4, 10 load PCin, 11 reserved (never generated).
- FETCH:
  - imem_req=1.
  - On imem_valid: IR←instr, go to DECODE. Otherwise stay.
  - imem_valid outside FETCH is ignored.
- DECODE:
  - Classify IR[31:21]. Register K.
  - Unknown opcode → HALT.
- EXEC (exactly 1 cycle):
  - R-type ADD/SUB/AND/ORR/ADDS/SUBS: DA=Rd, SA=Rn, SB=Rm, FS per op, regW=1, EN_ALU=1, SL=1 only for ADDS/SUBS, PS=01.
  - ADDI/SUBI: K=zero-ext imm12, selB=1, otherwise as R-type.
  - LDUR: SA=Rn, selB=1, K=sign-ext addr9, FS=ADD, no writes, PS=00; then go to MEM.
  - STUR: same address path, SB=Rt, ramW=1, PS=01.
  - B: K=pc+(sext imm26<<2), PCsel=1, PS=10.
  - CBZ/CBNZ: SB=Rt, selB=0, FS=PASS_B, K=pc+(sext imm19<<2), PCsel=1. Taken when statusOut[0]==1 (CBZ) or ==0 (CBNZ); PS=taken?10:01.
  - B.cond: same K; cond (EQ,NE,HS,LO,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL) evaluated on statusOut[4:1]; PS=taken?10:01.
  - BR: SA=Rn, PCsel=0, PS=10.
- MEM (LDUR only): same SA/K/FS/selB as EXEC, EN_MEM=1, regW=1, DA=Rt, PS=01.
- Exactly one EN_* asserted whenever regW=1.
- DA==31 forces regW=0 (XZR).
- retired increments on leaving EXEC (non-load) or MEM; wraps modulo 2^CNT_W.
- Next state after EXEC (non-load) or MEM is FETCH.
- HALT: sticky until reset; halted=1, imem_req=0, controlWord=0.
- Latency: 3 cycles minimum for ALU/store/branch, 4 for LDUR, plus any fetch wait cycles.

Decomposition:
- Shared package holds:
  - state enum (FETCH, DECODE, EXEC, MEM, HALT)
  - FS constants matching the ALU encoding (FS_AND, FS_OR, FS_ADD, FS_SUB, FS_PASS_B)
  - PS constants
  - opcode constants
  - B.cond codes
  - control-word field offsets
- One sub-module: seq_decoder — purely combinational; maps IR to instruction class, K value, and base control fields.

Test Plan:
- Reset held 2 cycles mid-EXEC of STUR → ramW never 1 during reset; next cycle state=FETCH, imem_req=1, retired=0.
- instr=0x910017E1 (ADDI X1,XZR,#5), imem_valid after 2 wait cycles → EXEC cycle shows DA=1, SA=31, selB=1, K=5, FS=FS_ADD, regW=1, EN_ALU=1, PS=01; retired=1.
- instr=0x8B020023 (ADD X3,X1,X2) → EXEC: DA=3, SA=1, SB=2, selB=0, SL=0, regW=1; 3 cycles fetch-to-fetch with imem_valid tied high.
- instr=0xF8408024 (LDUR X4,[X1,#8]) → EXEC: K=8, regW=0; MEM: EN_MEM=1, regW=1, DA=4, PS=01; 4 cycles total.
- instr=0xB4000061 (CBZ X1,+3), pc=0x100 → K=0x10C, PCsel=1. With statusOut[0]=1: PS=10. With statusOut[0]=0: PS=01.
- instr=0xFFFFFFFF → halted=1 one cycle after DECODE; imem_req stays 0 and controlWord=0 for 10 cycles; reset clears halted.
